// File: rtl/str_join_pkg.sv
// Shared types and constants for the string-join scheduler.
package str_join_pkg;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    STREAM = 2'd1,
    DELIM  = 2'd2
  } state_t;

  localparam logic [7:0] DEFAULT_DEL_CHAR = 8'h2C;
  localparam int         STAT_W           = 32;

endpackage

// File: rtl/str_join_sched_rr_arb.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module str_join_rr_arb #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_grant,
  output logic             o_grant_valid
);

  logic [IDX_W-1:0] w_idx;

  // Walk offsets downward so the smallest offset from the pointer wins.
  always_comb begin
    o_grant       = '0;
    o_grant_valid = 1'b0;
    w_idx         = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = IDX_W'((int'(i_ptr) + k) % N_REQ);
      if (i_req[w_idx]) begin
        o_grant       = w_idx;
        o_grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/str_join_sched.sv
// Round-robin fragment joiner with delimiter insertion; STR_JOIN_STATS_EN adds
// string/character counters (stat_strings, stat_chars, stat_clr).
module str_join_sched
  import str_join_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        s_valid,
  input  logic [N_REQ*DATA_W-1:0] s_data,
  input  logic [N_REQ-1:0]        s_last,
  output logic [N_REQ-1:0]        s_ready,
  input  logic [CNT_W-1:0]        cfg_count,
  input  logic [DATA_W-1:0]       cfg_del_char,
  input  logic                    cfg_del_en,
  output logic                    m_valid,
  output logic [DATA_W-1:0]       m_data,
  output logic                    m_last,
  input  logic                    m_ready,
  output logic                    busy
`ifdef STR_JOIN_STATS_EN
  ,
  input  logic                    stat_clr,
  output logic [STAT_W-1:0]       stat_strings,
  output logic [STAT_W-1:0]       stat_chars
`endif
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t             r_state;
  logic [IDX_W-1:0]   r_grant;
  logic [IDX_W-1:0]   r_rr;
  logic [CNT_W-1:0]   r_frag_idx;
  logic [CNT_W-1:0]   r_count;
  logic [DATA_W-1:0]  r_del_char;
  logic               r_del_en;

  state_t             w_state_nxt;
  logic [IDX_W-1:0]   w_arb_grant;
  logic               w_arb_gv;
  logic [IDX_W-1:0]   w_rr_nxt;
  logic               w_sel_valid;
  logic [DATA_W-1:0]  w_sel_data;
  logic               w_sel_last;
  logic               w_final_frag;
  logic               w_beat;
  logic               w_frag_end;

  str_join_rr_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req         (s_valid),
    .i_ptr         (r_rr),
    .o_grant       (w_arb_grant),
    .o_grant_valid (w_arb_gv)
  );

  assign w_rr_nxt     = (w_arb_grant == IDX_W'(N_REQ - 1)) ? '0 : w_arb_grant + IDX_W'(1);
  assign w_sel_valid  = s_valid[r_grant];
  assign w_sel_data   = s_data[r_grant*DATA_W +: DATA_W];
  assign w_sel_last   = s_last[r_grant];
  assign w_final_frag = (r_frag_idx == r_count - CNT_W'(1));
  assign w_beat       = (r_state == STREAM) && w_sel_valid && m_ready;
  assign w_frag_end   = w_beat && w_sel_last;
  assign busy         = (r_frag_idx != '0) || (r_state != ARB);

  always_comb begin
    w_state_nxt = r_state;
    m_valid     = 1'b0;
    m_data      = '0;
    m_last      = 1'b0;
    s_ready     = '0;
    case (r_state)
      ARB: begin
        if (w_arb_gv) w_state_nxt = STREAM;
      end
      STREAM: begin
        m_valid          = w_sel_valid;
        m_data           = w_sel_data;
        m_last           = w_sel_last && w_final_frag;
        s_ready[r_grant] = m_ready;
        if (w_frag_end) w_state_nxt = (w_final_frag || !r_del_en) ? ARB : DELIM;
      end
      DELIM: begin
        m_valid = 1'b1;
        m_data  = r_del_char;
        if (m_ready) w_state_nxt = ARB;
      end
      default: w_state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ARB;
      r_grant    <= '0;
      r_rr       <= '0;
      r_frag_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ARB && w_arb_gv) begin
        r_grant <= w_arb_grant;
        r_rr    <= w_rr_nxt;
      end
      if (w_frag_end) r_frag_idx <= w_final_frag ? '0 : r_frag_idx + CNT_W'(1);
    end
  end

  // Config is captured only when a new string's first fragment is granted.
  always_ff @(posedge clk) begin
    if (r_state == ARB && w_arb_gv && r_frag_idx == '0) begin
      r_count    <= (cfg_count == '0) ? CNT_W'(1) : cfg_count;
      r_del_char <= cfg_del_char;
      r_del_en   <= cfg_del_en;
    end
  end

`ifdef STR_JOIN_STATS_EN
  logic w_xfer;
  assign w_xfer = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_strings <= '0;
      stat_chars   <= '0;
    end else begin
      if (w_xfer)           stat_chars   <= stat_chars + STAT_W'(1);
      if (w_xfer && m_last) stat_strings <= stat_strings + STAT_W'(1);
    end
  end
`endif

endmodule
